allpass_chain_sequencer: RTL and testbench

//  Sequences one shared allpass datapath through NSTAGES cascaded reverb stages once per sample period.

---
 rtl/allpass_chain_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_allpass_chain_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/allpass_chain_sequencer.sv
// allpass_chain_sequencer
// Steps one shared allpass datapath through NSTAGES cascaded stages once per
// sample period. Per-stage tau/gain/bypass live in a shadow bank that software
// writes at any time; the shadow is copied into the active bank only when a
// sample starts, so every stage of one sample sees one consistent config.
//
// Datapath handshake: stage_start is a 1-cycle request, issued only from
// ISSUE. stage_sel/stage_in/stage_tau/stage_gain are valid in that cycle and
// stay stable until stage_done. stage_done is the response valid and is
// accepted only in WAIT, which always lasts at least one cycle. stage_done
// seen in any other state is ignored.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module allpass_chain_sequencer #(
  parameter int WIDTH       = 24,
  parameter int NSTAGES     = 4,
  parameter int DEFAULT_TAU = 1000,
  localparam int WORD       = WIDTH + `FIXED_POINT,
  localparam int SW         = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_clk,
  input  logic [WORD-1:0] in,
  input  logic            cfg_we,
  input  logic [SW-1:0]   cfg_addr,
  input  logic [WORD-1:0] cfg_tau,
  input  logic [WORD-1:0] cfg_gain,
  input  logic            cfg_bypass,
  output logic            stage_start,
  output logic [SW-1:0]   stage_sel,
  output logic [WORD-1:0] stage_in,
  output logic [WORD-1:0] stage_tau,
  output logic [WORD-1:0] stage_gain,
  input  logic            stage_done,
  input  logic [WORD-1:0] stage_out,
  output logic [WORD-1:0] out,
  output logic            out_valid,
  output logic            busy,
  output logic            overrun,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic            sample_clk_q;
  logic            tick;
  logic            start_seq;
  logic [WORD-1:0] acc;
  logic [SW-1:0]   sel;
  logic            last_stage;
  logic            cur_bypass;
  logic            advance;
  logic            load_result;

  logic [WORD-1:0] sh_tau    [NSTAGES];
  logic [WORD-1:0] sh_gain   [NSTAGES];
  logic            sh_bypass [NSTAGES];
  logic [WORD-1:0] act_tau   [NSTAGES];
  logic [WORD-1:0] act_gain  [NSTAGES];
  logic            act_bypass[NSTAGES];

  assign tick       = sample_clk && !sample_clk_q;
  assign start_seq  = (state == IDLE) && tick;
  assign last_stage = (int'(sel) == NSTAGES - 1);
  assign cur_bypass = act_bypass[sel];

  assign stage_sel  = sel;
  assign stage_in   = acc;
  assign stage_tau  = act_tau[sel];
  assign stage_gain = act_gain[sel];
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  // Edge detector for the sample strobe; resets high so a strobe held
  // through reset is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_clk_q <= 1'b1;
    else     sample_clk_q <= sample_clk;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode; a bypassed stage advances straight
  // from ISSUE without touching the datapath.
  always_comb begin
    state_next  = state;
    stage_start = 1'b0;
    advance     = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (tick) state_next = ISSUE;
      end
      ISSUE: begin
        if (cur_bypass) begin
          advance = 1'b1;
        end else begin
          stage_start = 1'b1;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (stage_done) begin
          load_result = 1'b1;
          advance     = 1'b1;
        end
      end
      PUBLISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (advance) state_next = last_stage ? PUBLISH : ISSUE;
  end

  // Accumulator, stage pointer, published output and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == PUBLISH);
      overrun   <= tick && (state != IDLE);
      if (start_seq) begin
        acc <= in;
        sel <= '0;
      end else begin
        if (load_result) acc <= stage_out;
        if (advance && !last_stage) sel <= sel + 1'b1;
      end
      if (state == PUBLISH) out <= acc;
    end
  end

  // Shadow bank: software writes land here in any cycle; out-of-range
  // stage indices are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGES; i++) begin
        sh_tau[i]    <= WORD'(DEFAULT_TAU);
        sh_gain[i]   <= '0;
        sh_bypass[i] <= 1'b0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NSTAGES)) begin
      sh_tau[cfg_addr]    <= cfg_tau;
      sh_gain[cfg_addr]   <= cfg_gain;
      sh_bypass[cfg_addr] <= cfg_bypass;
    end
  end

  // Active bank: snapshot of the shadow taken at the start of a sample.
  // The copy reads the shadow before any write in the same cycle lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGES; i++) begin
        act_tau[i]    <= WORD'(DEFAULT_TAU);
        act_gain[i]   <= '0;
        act_bypass[i] <= 1'b0;
      end
    end else if (start_seq) begin
      for (int i = 0; i < NSTAGES; i++) begin
        act_tau[i]    <= sh_tau[i];
        act_gain[i]   <= sh_gain[i];
        act_bypass[i] <= sh_bypass[i];
      end
    end
  end

endmodule

// File: tb/tb_allpass_chain_sequencer.sv
// Testbench for allpass_chain_sequencer: stub datapath (result = input + 1,
// per-stage latency chosen by the bench), a sequence-level reference model
// and a scoreboard of expected stage starts and published outputs.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module tb_allpass_chain_sequencer;

  localparam int WIDTH       = 24;
  localparam int NSTAGES     = 4;
  localparam int DEFAULT_TAU = 1000;
  localparam int WORD        = WIDTH + `FIXED_POINT;
  localparam int SW          = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_clk = 1'b1;
  logic [WORD-1:0] din = '0;
  logic            cfg_we = 1'b0;
  logic [SW-1:0]   cfg_addr = '0;
  logic [WORD-1:0] cfg_tau = '0;
  logic [WORD-1:0] cfg_gain = '0;
  logic            cfg_bypass = 1'b0;
  logic            stage_start;
  logic [SW-1:0]   stage_sel;
  logic [WORD-1:0] stage_in;
  logic [WORD-1:0] stage_tau;
  logic [WORD-1:0] stage_gain;
  logic            stage_done = 1'b0;
  logic [WORD-1:0] stage_out = '0;
  logic [WORD-1:0] dout;
  logic            out_valid;
  logic            busy;
  logic            overrun;
  logic [1:0]      state_dbg;

  allpass_chain_sequencer #(
    .WIDTH(WIDTH), .NSTAGES(NSTAGES), .DEFAULT_TAU(DEFAULT_TAU)
  ) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .in(din),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_tau(cfg_tau),
    .cfg_gain(cfg_gain), .cfg_bypass(cfg_bypass),
    .stage_start(stage_start), .stage_sel(stage_sel), .stage_in(stage_in),
    .stage_tau(stage_tau), .stage_gain(stage_gain),
    .stage_done(stage_done), .stage_out(stage_out),
    .out(dout), .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stub datapath ----------------
  int lat_cfg[NSTAGES];
  int rem = 0;
  always @(posedge clk) begin
    if (stage_start) begin
      rem        <= lat_cfg[stage_sel] - 1;
      stage_done <= (lat_cfg[stage_sel] == 1);
      stage_out  <= stage_in + 1'b1;
    end else if (rem > 0) begin
      rem        <= rem - 1;
      stage_done <= (rem == 1);
    end else begin
      stage_done <= 1'b0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [WORD-1:0] m_tau [NSTAGES];
  logic [WORD-1:0] m_gain[NSTAGES];
  bit              m_byp [NSTAGES];

  logic [SW-1:0]   exp_sel_q [$];
  logic [WORD-1:0] exp_tau_q [$];
  logic [WORD-1:0] exp_gain_q[$];
  logic [WORD-1:0] exp_in_q  [$];

  logic [WORD-1:0] exp_out;
  int exp_lat = 0;
  int tick_cyc = 0;
  bit seq_open = 0;
  int obs_starts = 0;
  int obs_valids = 0;
  int obs_overruns = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSTAGES; i++) begin
      m_tau[i]  = WORD'(DEFAULT_TAU);
      m_gain[i] = '0;
      m_byp[i]  = 0;
    end
    exp_sel_q.delete(); exp_tau_q.delete(); exp_gain_q.delete(); exp_in_q.delete();
    seq_open = 0;
  endtask

  // One clock cycle: wait for the falling edge, release one-cycle pulses,
  // then compare everything the DUT shows against the scoreboard.
  task automatic step();
    @(negedge clk);
    cfg_we     = 1'b0;
    sample_clk = 1'b0;
    if (stage_start) begin
      obs_starts++;
      if (exp_sel_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        check("start_sel",  stage_sel,  exp_sel_q.pop_front());
        check("start_tau",  stage_tau,  exp_tau_q.pop_front());
        check("start_gain", stage_gain, exp_gain_q.pop_front());
        check("start_in",   stage_in,   exp_in_q.pop_front());
      end
    end
    if (overrun) obs_overruns++;
    if (out_valid) begin
      obs_valids++;
      if (!seq_open) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out", dout, exp_out);
        check("latency", cyc - tick_cyc, exp_lat);
        seq_open = 0;
      end
    end
  endtask

  // Drive a config write for the coming cycle and record it in the shadow model.
  task automatic cfg_on(input int a, input logic [WORD-1:0] t, input logic [WORD-1:0] g, input bit b);
    cfg_we     = 1'b1;
    cfg_addr   = SW'(a);
    cfg_tau    = t;
    cfg_gain   = g;
    cfg_bypass = b;
    if (a < NSTAGES) begin
      m_tau[a] = t; m_gain[a] = g; m_byp[a] = b;
    end
  endtask

  // Raise the strobe for the coming cycle and predict the whole sequence:
  // the stage starts, the published word and the cycle it appears in.
  task automatic tick(input logic [WORD-1:0] d);
    logic [WORD-1:0] a;
    int lat;
    sample_clk = 1'b1;
    din        = d;
    tick_cyc   = cyc;
    a   = d;
    lat = 2;
    for (int s = 0; s < NSTAGES; s++) begin
      if (m_byp[s]) begin
        lat += 1;
      end else begin
        exp_sel_q.push_back(SW'(s));
        exp_tau_q.push_back(m_tau[s]);
        exp_gain_q.push_back(m_gain[s]);
        exp_in_q.push_back(a);
        a   = a + 1'b1;
        lat += lat_cfg[s] + 1;
      end
    end
    exp_out  = a;
    exp_lat  = lat;
    seq_open = 1;
  endtask

  task automatic run_seq(input logic [WORD-1:0] d, input int overrun_at, input bit mid_write, input bit rand_cfg);
    int n_exp;
    obs_starts = 0; obs_valids = 0; obs_overruns = 0;
    tick(d);
    n_exp = exp_sel_q.size();
    if (rand_cfg && $urandom_range(0, 1) == 0)
      cfg_on($urandom_range(0, NSTAGES - 1), $urandom, $urandom, $urandom_range(0, 2) == 0);
    for (int k = 0; k < 300 && seq_open; k++) begin
      step();
      if (k == overrun_at) sample_clk = 1'b1;
      if (mid_write && k == 4) cfg_on(2, 50, 128, 0);
      if (rand_cfg && $urandom_range(0, 3) == 0)
        cfg_on($urandom_range(0, NSTAGES - 1), $urandom, $urandom, $urandom_range(0, 2) == 0);
    end
    if (seq_open) begin
      check("timeout", 0, 1);
      seq_open = 0;
    end
    repeat (3) step();
    check("start_count", obs_starts, n_exp);
    check("valid_count", obs_valids, 1);
    check("overrun_count", obs_overruns, (overrun_at >= 0) ? 1 : 0);
    check("leftover_starts", exp_sel_q.size(), 0);
    check("busy_after", busy, 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    model_reset();
    for (int i = 0; i < NSTAGES; i++) lat_cfg[i] = 3;

    // Reset with the strobe held high throughout.
    repeat (3) @(negedge clk);
    check("rst_out", dout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_stage_start", stage_start, 0);
    check("rst_stage_sel", stage_sel, 0);
    check("rst_stage_in", stage_in, 0);
    check("rst_stage_tau", stage_tau, DEFAULT_TAU);
    check("rst_stage_gain", stage_gain, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("held_strobe_no_start", busy, 0);
    step();
    step();

    // Basic chain: four active stages, latency 3 each.
    run_seq(100, -1, 0, 0);

    // Shadow write mid-sequence applies only from the next sample.
    run_seq(200, -1, 1, 0);
    run_seq(300, -1, 0, 0);

    // Bypass stages 1 and 3.
    cfg_on(1, m_tau[1], m_gain[1], 1); step();
    cfg_on(3, m_tau[3], m_gain[3], 1); step();
    run_seq(40, -1, 0, 0);

    // Everything bypassed, negative input passes through.
    cfg_on(0, m_tau[0], m_gain[0], 1); step();
    cfg_on(2, m_tau[2], m_gain[2], 1); step();
    run_seq(-7, -1, 0, 0);

    // Re-enable all stages; second strobe edge during WAIT is an overrun.
    for (int i = 0; i < NSTAGES; i++) begin
      cfg_on(i, m_tau[i], m_gain[i], 0); step();
    end
    run_seq(10, 2, 0, 0);
    // Strobe edge in the PUBLISH cycle is dropped as well.
    run_seq(20, exp_lat - 2, 0, 0);

    // Reset while waiting on the datapath; the late done must be ignored.
    obs_starts = 0; obs_valids = 0; obs_overruns = 0;
    tick(5);
    step();
    step();
    step();
    rst = 1'b1;
    model_reset();
    obs_starts = 0;
    step();
    rst = 1'b0;
    repeat (8) step();
    check("abort_starts", obs_starts, 0);
    check("abort_valids", obs_valids, 0);
    check("abort_busy", busy, 0);
    check("abort_out", dout, 0);
    check("abort_tau_default", stage_tau, DEFAULT_TAU);
    run_seq(77, -1, 0, 0);

    // Randomized sequences with random latencies and config traffic.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NSTAGES; i++) lat_cfg[i] = $urandom_range(1, 4);
      run_seq($urandom, -1, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
